// File: rtl/data_mem_pkg.sv
// Shared address map, STATUS/CONTROL bit positions and decode enum for data_mem_responder.
// Optional feature macro used by the top level: DATA_MEM_CYCLE_COUNTER_EN.
package data_mem_pkg;

    localparam logic [31:0] ADDR_OUT_DATA = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS   = 32'h8000_0004;
    localparam logic [31:0] ADDR_CONTROL  = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLE    = 32'h8000_000C;

    localparam int STATUS_EMPTY_BIT  = 0;
    localparam int STATUS_FULL_BIT   = 1;
    localparam int STATUS_OVF_BIT    = 2;
    localparam int STATUS_COUNT_LSB  = 4;

    localparam int CONTROL_CLR_OVF_BIT = 0;
    localparam int CONTROL_FLUSH_BIT   = 1;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_RAM,
        DEC_OUT_DATA,
        DEC_STATUS,
        DEC_CONTROL,
        DEC_CYCLE
    } dec_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO feeding the JPEG output stream; DEPTH must be a power of two (>= 2).
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign count   = cnt;
    assign head    = store[rd_ptr];
    // A full FIFO can still accept a byte when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= 8'h00;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Zero-latency data RAM plus memory-mapped JPEG byte FIFO, STATUS/CONTROL and optional CYCLE counter.
// Define DATA_MEM_CYCLE_COUNTER_EN to build the free-running cycle counter readable at CYCLE.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ramaddress,
    input  logic             writeram,
    input  logic [WIDTH-1:0] writeramdata,
    output logic [WIDTH-1:0] readramdata,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH_WORDS];
    logic [WIDTH-1:0] word_addr;
    logic [AW-1:0]    ram_index;
    dec_e             dec;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic             clear_overflow;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] cycle_value;

    // Byte lane bits are masked rather than dropped so every address bit participates.
    assign word_addr = ramaddress & ~WIDTH'(3);
    assign ram_index = word_addr[AW+1:2];

    always_comb begin
        dec = DEC_NONE;
        if (word_addr < WIDTH'(DEPTH_WORDS * 4)) begin
            dec = DEC_RAM;
        end else if (word_addr == WIDTH'(ADDR_OUT_DATA)) begin
            dec = DEC_OUT_DATA;
        end else if (word_addr == WIDTH'(ADDR_STATUS)) begin
            dec = DEC_STATUS;
        end else if (word_addr == WIDTH'(ADDR_CONTROL)) begin
            dec = DEC_CONTROL;
        end else if (word_addr == WIDTH'(ADDR_CYCLE)) begin
            dec = DEC_CYCLE;
        end
    end

    always_ff @(posedge clock) begin
        if (writeram && dec == DEC_RAM) begin
            mem[ram_index] <= writeramdata;
        end
    end

    assign fifo_pop       = !fifo_empty && out_ready;
    assign fifo_push      = writeram && (dec == DEC_OUT_DATA);
    assign fifo_flush     = writeram && (dec == DEC_CONTROL) && writeramdata[CONTROL_FLUSH_BIT];
    assign clear_overflow = writeram && (dec == DEC_CONTROL) && writeramdata[CONTROL_CLR_OVF_BIT];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (writeramdata[7:0]),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;

    // Sticky until software clears it; a push that lands on a departing head is not an overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status                            = '0;
        status[STATUS_EMPTY_BIT]          = fifo_empty;
        status[STATUS_FULL_BIT]           = fifo_full;
        status[STATUS_OVF_BIT]            = overflow;
        status[STATUS_COUNT_LSB +: CW]    = fifo_count;
    end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [WIDTH-1:0] cycle_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + WIDTH'(1);
        end
    end

    assign cycle_value = cycle_count;
`else
    assign cycle_value = '0;
`endif

    always_comb begin
        case (dec)
            DEC_RAM:    readramdata = mem[ram_index];
            DEC_STATUS: readramdata = status;
            DEC_CYCLE:  readramdata = cycle_value;
            default:    readramdata = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (honours DATA_MEM_CYCLE_COUNTER_EN).
module tb_data_mem_responder;

    localparam logic [31:0] A_OUT  = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CTRL = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ramaddress;
    logic        writeram;
    logic [31:0] writeramdata;
    logic [31:0] readramdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .ramaddress   (ramaddress),
        .writeram     (writeram),
        .writeramdata (writeramdata),
        .readramdata  (readramdata),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        ramaddress   = addr;
        writeramdata = data;
        writeram     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        writeram = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        ramaddress = addr;
        #1;
        data = readramdata;
    endtask

    task automatic drain(input string tag, input logic [7:0] first, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(first + 8'(i)));
            @(negedge clock);
        end
        out_ready = 1'b0;
        #1;
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] rd2;

    initial begin
        reset        = 1'b1;
        ramaddress   = '0;
        writeram     = 1'b0;
        writeramdata = '0;
        out_ready    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        do_read(A_STAT, rd);
        check("rst_status", rd, 32'h1);

        // RAM write/read and same-cycle read returns old value
        do_write(32'h10, 32'hDEAD_BEEF);
        do_read(32'h10, rd);
        check("ram_rd", rd, 32'hDEAD_BEEF);
        do_read(32'h13, rd);
        check("ram_bytelane", rd, 32'hDEAD_BEEF);
        ramaddress   = 32'h10;
        writeramdata = 32'h1234_5678;
        writeram     = 1'b1;
        #1;
        check("ram_old", readramdata, 32'hDEAD_BEEF);
        @(posedge clock);
        @(negedge clock);
        writeram = 1'b0;
        do_read(32'h10, rd);
        check("ram_new", rd, 32'h1234_5678);

        // RAM upper boundary, no aliasing beyond it
        do_write(32'h0, 32'hA5A5_0001);
        do_write(32'hFFC, 32'hCAFE_F00D);
        do_read(32'hFFC, rd);
        check("ram_top", rd, 32'hCAFE_F00D);
        do_write(32'h1000, 32'h0BAD_0BAD);
        do_read(32'h1000, rd);
        check("beyond_ram_rd", rd, 32'h0);
        do_read(32'h0, rd);
        check("no_alias", rd, 32'hA5A5_0001);
        do_write(A_STAT, 32'hFFFF_FFFF);
        do_read(A_STAT, rd);
        check("status_ro", rd, 32'h1);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) do_write(A_OUT, 32'h11 + 32'(i));
        do_read(A_STAT, rd);
        check("full_status", rd, 32'h82);
        do_write(A_OUT, 32'h99);
        do_read(A_STAT, rd);
        check("ovf_status", rd, 32'h86);
        repeat (3) @(negedge clock);
        #1;
        check("stall_data", 32'(out_data), 32'h11);
        drain("drain1", 8'h11, 8);
        do_read(A_STAT, rd);
        check("after_drain", rd, 32'h5);
        do_write(A_CTRL, 32'h1);
        do_read(A_STAT, rd);
        check("ovf_clear", rd, 32'h1);

        // Push into full FIFO while head pops
        for (int i = 0; i < 8; i++) do_write(A_OUT, 32'h21 + 32'(i));
        out_ready = 1'b1;
        do_write(A_OUT, 32'h29);
        out_ready = 1'b0;
        do_read(A_STAT, rd);
        check("push_pop_full", rd, 32'h82);
        drain("drain2", 8'h22, 8);

        // Flush with bytes queued
        for (int i = 0; i < 3; i++) do_write(A_OUT, 32'h31 + 32'(i));
        do_write(A_CTRL, 32'h2);
        #1;
        check("flush_valid", 32'(out_valid), 32'd0);
        do_read(A_STAT, rd);
        check("flush_status", rd, 32'h1);
        do_write(A_OUT, 32'h55);
        #1;
        check("post_flush_head", 32'(out_data), 32'h55);
        do_write(A_CTRL, 32'h2);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) do_write(A_OUT, 32'h41 + 32'(i));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        do_read(A_STAT, rd);
        check("midrst_status", rd, 32'h1);
        do_read(32'h8000_0100, rd);
        check("unmapped_rd", rd, 32'h0);
        do_read(A_OUT, rd);
        check("wo_out_rd", rd, 32'h0);
        do_read(A_CTRL, rd);
        check("wo_ctrl_rd", rd, 32'h0);

        // Cycle counter
        @(negedge clock);
        do_read(A_CYC, rd);
        repeat (10) @(negedge clock);
        do_read(A_CYC, rd2);
`ifdef DATA_MEM_CYCLE_COUNTER_EN
        check("cycle_delta", rd2 - rd, 32'd10);
`else
        check("cycle_zero_a", rd, 32'h0);
        check("cycle_zero_b", rd2, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
